bench_run_sequencer: RTL and testbench

Multi-iteration scheduler for the bench engine. It issues a programmed number of start pulses to the engine, one per run, and waits for each done. Per run it accumulates winner histograms and the winning condition's cycle count. It guards each run with a timeout. It sits between the AXI-Lite register block (command/config/readback) and the bench engine (start/done/timing outputs).

---
 rtl/bench_run_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bench_run_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_run_sequencer.sv
// Multi-run scheduler for the bench engine: issues one start per run, collects
// per-condition win counts and the winning-time sum, and guards each run with a timeout.
module bench_run_sequencer #(
    parameter int ITER_W      = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int GAP_CYC     = 16,
    parameter int SUM_W       = 48
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [ITER_W-1:0] cfg_iterations,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [31:0]       eng_t0,
    input  logic [31:0]       eng_t1,
    input  logic [31:0]       eng_t2,
    input  logic [31:0]       eng_t3,
    input  logic [1:0]        eng_winner_code,
    output logic              busy,
    output logic              seq_done,
    output logic              aborted,
    output logic              timeout_err,
    output logic [ITER_W-1:0] iter_count,
    output logic [ITER_W-1:0] win_cnt0,
    output logic [ITER_W-1:0] win_cnt1,
    output logic [ITER_W-1:0] win_cnt2,
    output logic [ITER_W-1:0] win_cnt3,
    output logic [SUM_W-1:0]  sum_win_t
);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int ACC_W   = ((SUM_W > 32) ? SUM_W : 32) + 1;
    localparam bit HAS_GAP = (GAP_CYC > 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t            state, state_nx;
    logic [ITER_W-1:0] target;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ITER_W-1:0] win_cnt [4];
    logic [31:0]       t_sel;
    logic              accept, run_ok, to_hit, abort_hit, last_run;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + ITER_W'(1);
    endfunction

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [31:0] b);
        logic [ACC_W-1:0] s;
        s = ACC_W'(a) + ACC_W'(b);
        return ((s >> SUM_W) != '0) ? '1 : s[SUM_W-1:0];
    endfunction

    always_comb begin
        case (eng_winner_code)
            2'd0:    t_sel = eng_t0;
            2'd1:    t_sel = eng_t1;
            2'd2:    t_sel = eng_t2;
            default: t_sel = eng_t3;
        endcase
    end

    assign last_run = (iter_count + ITER_W'(1)) == target;

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        run_ok    = 1'b0;
        to_hit    = 1'b0;
        abort_hit = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                // start wins over a simultaneous abort; abort alone is ignored here
                if (cmd_start) begin
                    accept   = 1'b1;
                    state_nx = (cfg_iterations == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_abort) begin
                    abort_hit = 1'b1;
                    state_nx  = S_DONE;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // abort beats both a same-cycle done and a same-cycle timeout
                if (cmd_abort) begin
                    abort_hit = 1'b1;
                    state_nx  = S_DONE;
                end else if (eng_done) begin
                    run_ok = 1'b1;
                    if (last_run)     state_nx = S_DONE;
                    else if (HAS_GAP) state_nx = S_GAP;
                    else              state_nx = S_ISSUE;
                end else if (to_cnt == TO_LAST) begin
                    to_hit   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_GAP: begin
                if (cmd_abort) begin
                    abort_hit = 1'b1;
                    state_nx  = S_DONE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nx = S_ISSUE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);
    assign seq_done  = (state == S_DONE);
    assign eng_start = (state == S_ISSUE) && !cmd_abort;
    assign win_cnt0  = win_cnt[0];
    assign win_cnt1  = win_cnt[1];
    assign win_cnt2  = win_cnt[2];
    assign win_cnt3  = win_cnt[3];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state       <= S_IDLE;
            target      <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            iter_count  <= '0;
            sum_win_t   <= '0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 4; i++) win_cnt[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                target      <= cfg_iterations;
                iter_count  <= '0;
                sum_win_t   <= '0;
                aborted     <= 1'b0;
                timeout_err <= 1'b0;
                for (int i = 0; i < 4; i++) win_cnt[i] <= '0;
            end
            if (state == S_ISSUE)     to_cnt <= '0;
            else if (state == S_WAIT) to_cnt <= to_cnt + TO_W'(1);
            if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                gap_cnt <= '0;
            if (run_ok) begin
                iter_count               <= iter_count + ITER_W'(1);
                win_cnt[eng_winner_code] <= sat_inc(win_cnt[eng_winner_code]);
                sum_win_t                <= sat_add(sum_win_t, t_sel);
            end
            if (abort_hit) aborted     <= 1'b1;
            if (to_hit)    timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bench_run_sequencer.sv
// Directed bench for bench_run_sequencer: table of whole sequences driven through an
// engine model, plus hand-written corner sequences and a narrow-counter instance.
module tb_bench_run_sequencer;
    typedef struct packed {
        logic [15:0]      iters;
        int               delay;
        int               abort_run;
        bit               busy_start;
        bit               abort_with_start;
        logic [5:0][1:0]  win;
        logic [5:0][31:0] t;
        logic [15:0]      e_iter, e_w0, e_w1, e_w2, e_w3;
        logic [47:0]      e_sum;
        bit               e_ab, e_to;
        int               e_starts, e_lat;
    } vec_t;

    localparam int NV = 6;

    logic clk, rst_n;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    // instance A: wide counters, gap 4, timeout 50
    logic [15:0] cfg_a, iter_a, wa0, wa1, wa2, wa3;
    logic        start_a, tb_abort, model_abort, cmd_abort_a;
    logic        eng_start_a, eng_done_a, busy_a, sd_a, ab_a, to_a;
    logic [31:0] t_a [4];
    logic [1:0]  win_a;
    logic [47:0] sum_a;

    // instance B: 2-bit counters, 32-bit sum, no gap
    logic [1:0]  cfg_b, iter_b, wb0, wb1, wb2, wb3, win_b;
    logic        start_b, abort_b, eng_start_b, done_b, busy_b, sd_b, ab_b, to_b;
    logic [31:0] t_b [4];
    logic [31:0] sum_b;

    vec_t vt [NV];
    vec_t cur;

    int n_starts, last_start_cyc, last_done_cyc, sp_min, sp_max;
    bit last_done_ok;

    assign cmd_abort_a = tb_abort | model_abort;

    bench_run_sequencer #(.ITER_W(16), .TIMEOUT_CYC(50), .GAP_CYC(4), .SUM_W(48)) dut_a (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .cfg_iterations(cfg_a),
        .cmd_start(start_a), .cmd_abort(cmd_abort_a), .eng_start(eng_start_a),
        .eng_done(eng_done_a), .eng_t0(t_a[0]), .eng_t1(t_a[1]), .eng_t2(t_a[2]),
        .eng_t3(t_a[3]), .eng_winner_code(win_a), .busy(busy_a), .seq_done(sd_a),
        .aborted(ab_a), .timeout_err(to_a), .iter_count(iter_a), .win_cnt0(wa0),
        .win_cnt1(wa1), .win_cnt2(wa2), .win_cnt3(wa3), .sum_win_t(sum_a));

    bench_run_sequencer #(.ITER_W(2), .TIMEOUT_CYC(8), .GAP_CYC(0), .SUM_W(32)) dut_b (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .cfg_iterations(cfg_b),
        .cmd_start(start_b), .cmd_abort(abort_b), .eng_start(eng_start_b),
        .eng_done(done_b), .eng_t0(t_b[0]), .eng_t1(t_b[1]), .eng_t2(t_b[2]),
        .eng_t3(t_b[3]), .eng_winner_code(win_b), .busy(busy_b), .seq_done(sd_b),
        .aborted(ab_b), .timeout_err(to_b), .iter_count(iter_b), .win_cnt0(wb0),
        .win_cnt1(wb1), .win_cnt2(wb2), .win_cnt3(wb3), .sum_win_t(sum_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Engine model for instance A: answers each eng_start after cur.delay cycles
    // (never when delay is 0) and optionally raises abort together with a chosen done.
    initial begin : engine_model
        int idx;
        eng_done_a = 1'b0; model_abort = 1'b0; win_a = 2'd0;
        for (int i = 0; i < 4; i++) t_a[i] = 32'd0;
        n_starts = 0; last_start_cyc = 0; last_done_cyc = 0;
        sp_min = 1 << 30; sp_max = 0; last_done_ok = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            eng_done_a  = 1'b0;
            model_abort = 1'b0;
            if (start_a && !busy_a) begin
                n_starts = 0; sp_min = 1 << 30; sp_max = 0; last_done_ok = 1'b0;
            end
            if (eng_start_a) begin
                n_starts++;
                last_start_cyc = cyc;
                if (last_done_ok) begin
                    if (cyc - last_done_cyc < sp_min) sp_min = cyc - last_done_cyc;
                    if (cyc - last_done_cyc > sp_max) sp_max = cyc - last_done_cyc;
                end
                if (cur.delay > 0) begin
                    idx = (n_starts - 1) % 6;
                    repeat (cur.delay) @(negedge clk);
                    for (int i = 0; i < 4; i++) t_a[i] = 32'd7777;
                    win_a        = cur.win[idx];
                    t_a[win_a]   = cur.t[idx];
                    eng_done_a   = 1'b1;
                    model_abort  = (n_starts == cur.abort_run);
                    last_done_cyc = cyc;
                    last_done_ok  = 1'b1;
                end
            end
        end
    end

    task automatic set_in(input int k, input int it, input int dly, input int abr, input bit bs, input bit aws);
        vt[k] = '0;
        vt[k].iters = 16'(it); vt[k].delay = dly; vt[k].abort_run = abr;
        vt[k].busy_start = bs; vt[k].abort_with_start = aws;
    endtask

    task automatic set_run(input int k, input int r, input logic [1:0] w, input logic [31:0] tv);
        vt[k].win[r] = w;
        vt[k].t[r]   = tv;
    endtask

    task automatic set_exp(input int k, input int it, input int w0, input int w1, input int w2, input int w3,
                           input logic [47:0] s, input bit ab, input bit to, input int ns, input int lat);
        vt[k].e_iter = 16'(it); vt[k].e_w0 = 16'(w0); vt[k].e_w1 = 16'(w1);
        vt[k].e_w2 = 16'(w2); vt[k].e_w3 = 16'(w3); vt[k].e_sum = s;
        vt[k].e_ab = ab; vt[k].e_to = to; vt[k].e_starts = ns; vt[k].e_lat = lat;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        bit   seen;
        int   lat;
        v = vt[k];
        cur = v;
        @(negedge clk);
        cfg_a = v.iters; start_a = 1'b1; tb_abort = v.abort_with_start;
        @(negedge clk);
        start_a = 1'b0; tb_abort = 1'b0; cfg_a = 16'hBEEF;
        if (v.busy_start) begin
            repeat (3) @(negedge clk);
            start_a = 1'b1; cfg_a = 16'd9;
            @(negedge clk);
            start_a = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (sd_a) seen = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d_seq_done_reached", k), 64'(seen), 64'd1);
        lat = cyc - last_start_cyc;
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_iter_count", k), 64'(iter_a), 64'(v.e_iter));
        chk($sformatf("v%0d_win_cnt", k), {wa0, wa1, wa2, wa3}, {v.e_w0, v.e_w1, v.e_w2, v.e_w3});
        chk($sformatf("v%0d_sum_win_t", k), 64'(sum_a), 64'(v.e_sum));
        chk($sformatf("v%0d_flags_ab_to", k), {62'd0, ab_a, to_a}, {62'd0, v.e_ab, v.e_to});
        chk($sformatf("v%0d_done_busy", k), {62'd0, sd_a, busy_a}, 64'd2);
        chk($sformatf("v%0d_eng_starts", k), 64'(n_starts), 64'(v.e_starts));
        if (v.e_lat != 0) chk($sformatf("v%0d_last_start_to_done", k), 64'(lat), 64'(v.e_lat));
        if (v.e_starts > 1) chk($sformatf("v%0d_start_spacing", k), {32'(sp_min), 32'(sp_max)}, {32'd5, 32'd5});
    endtask

    initial begin : main
        int s;
        rst_n = 1'b0; start_a = 1'b0; tb_abort = 1'b0; cfg_a = '0;
        cfg_b = '0; start_b = 1'b0; abort_b = 1'b0; done_b = 1'b0; win_b = '0;
        for (int i = 0; i < 4; i++) t_b[i] = 32'd0;
        cur = '0;

        set_in(0, 3, 10, 0, 0, 0);
        set_run(0, 0, 2'd3, 32'd100); set_run(0, 1, 2'd3, 32'd120); set_run(0, 2, 2'd1, 32'd90);
        set_exp(0, 3, 0, 1, 0, 2, 48'd310, 0, 0, 3, 11);
        set_in(1, 0, 10, 0, 0, 0);
        set_exp(1, 0, 0, 0, 0, 0, 48'd0, 0, 0, 0, 0);
        set_in(2, 2, 0, 0, 0, 0);
        set_exp(2, 0, 0, 0, 0, 0, 48'd0, 0, 1, 1, 51);
        set_in(3, 5, 10, 2, 0, 0);
        set_run(3, 0, 2'd2, 32'd50); set_run(3, 1, 2'd0, 32'd60);
        set_exp(3, 1, 0, 0, 1, 0, 48'd50, 1, 0, 2, 11);
        set_in(4, 2, 6, 0, 1, 0);
        set_run(4, 0, 2'd0, 32'd1000); set_run(4, 1, 2'd2, 32'd2000);
        set_exp(4, 2, 1, 0, 1, 0, 48'd3000, 0, 0, 2, 7);
        set_in(5, 4, 3, 0, 0, 1);
        set_run(5, 0, 2'd0, 32'hFFFF_FFFF); set_run(5, 1, 2'd1, 32'd1);
        set_run(5, 2, 2'd2, 32'd2); set_run(5, 3, 2'd3, 32'd3);
        set_exp(5, 4, 1, 1, 1, 1, 48'h1_0000_0005, 0, 0, 4, 4);

        repeat (4) @(negedge clk);
        chk("reset_outputs_a", {busy_a, sd_a, ab_a, to_a, eng_start_a, iter_a, wa0, wa1, wa2, wa3, sum_a}, '0);
        chk("reset_outputs_b", {busy_b, sd_b, ab_b, to_b, eng_start_b, iter_b, wb0, wb1, wb2, wb3, sum_b}, '0);
        chk("reset_no_eng_start", 64'(n_starts), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", {62'd0, busy_a, sd_a}, 64'd0);

        // zero iterations from IDLE: DONE on the very next cycle, no start
        cfg_a = 16'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("zero_iter_done_next_cycle", {61'd0, sd_a, busy_a, eng_start_a}, 64'd4);
        repeat (3) @(negedge clk);
        chk("zero_iter_no_start", 64'(n_starts), 64'd0);

        for (int k = 0; k < NV; k++) run_vec(k);

        // abort during ISSUE suppresses that cycle's eng_start
        cur = vt[2];
        cfg_a = 16'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; tb_abort = 1'b1;
        #2;
        chk("issue_abort_start_suppressed", {62'd0, busy_a, eng_start_a}, 64'd2);
        @(negedge clk);
        tb_abort = 1'b0;
        chk("issue_abort_flags", {61'd0, sd_a, ab_a, to_a}, 64'd6);
        repeat (3) @(negedge clk);
        chk("issue_abort_no_start", 64'(n_starts), 64'd0);

        // abort landing on the timeout cycle: abort wins
        cfg_a = 16'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 10 && n_starts != 1; i++) @(negedge clk);
        s = last_start_cyc;
        for (int i = 0; i < 200 && cyc < s + 50; i++) @(negedge clk);
        tb_abort = 1'b1;
        @(negedge clk);
        tb_abort = 1'b0;
        chk("abort_vs_timeout_flags", {61'd0, sd_a, ab_a, to_a}, 64'd6);
        chk("abort_vs_timeout_iter", 64'(iter_a), 64'd0);

        // instance B: done in IDLE ignored, then 3 runs with saturating sum
        @(negedge clk);
        done_b = 1'b1; win_b = 2'd1; t_b[1] = 32'd5;
        @(negedge clk);
        done_b = 1'b0;
        chk("b_idle_done_ignored", {iter_b, wb1, sum_b}, '0);
        cfg_b = 2'd3; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_first_start", 64'(eng_start_b), 64'd1);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            done_b = 1'b1; win_b = 2'd0; t_b[0] = 32'hC000_0000;
            t_b[1] = 32'd1; t_b[2] = 32'd1; t_b[3] = 32'd1;
            @(negedge clk);
            done_b = 1'b0;
            chk($sformatf("b_iter_after_run%0d", r), 64'(iter_b), 64'(r + 1));
            chk($sformatf("b_sum_after_run%0d", r), 64'(sum_b), (r == 0) ? 64'hC000_0000 : 64'hFFFF_FFFF);
            if (r < 2) chk($sformatf("b_restart_no_gap%0d", r), 64'(eng_start_b), 64'd1);
        end
        chk("b_final_state", {60'd0, sd_b, busy_b, ab_b, to_b}, 64'd8);
        chk("b_win_cnt0", {wb0, wb1, wb2, wb3}, {2'd3, 2'd0, 2'd0, 2'd0});
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("b_done_in_done_ignored", 64'(iter_b), 64'd3);

        // asynchronous reset in the middle of a sequence
        cur = vt[0];
        cfg_a = 16'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 100 && iter_a != 16'd1; i++) @(negedge clk);
        chk("mid_seq_progress", 64'(iter_a), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs_a", {busy_a, sd_a, ab_a, to_a, eng_start_a, iter_a, wa0, wa1, wa2, wa3, sum_a}, '0);
        chk("mid_reset_outputs_b", {busy_b, sd_b, ab_b, to_b, eng_start_b, iter_b, wb0, wb1, wb2, wb3, sum_b}, '0);
        s = n_starts;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_reset_no_restart", 64'(n_starts), 64'(s));
        chk("mid_reset_idle", {62'd0, busy_a, sd_a}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
